h8_dmem_arbiter: RTL
====================

Name: h8_dmem_arbiter

Overview:
Shares the single data-memory port between the h8_core data interface and a host requester, such as a debug or loader bus. The core cannot be back-pressured, so it has absolute priority. Host requests sit in a one-entry holding register and issue into idle memory cycles. Memory is a 256x8 SRAM with fixed 1-cycle read latency; the block sits between the core's o_dmem_* / i_dmem_rsp_data and the SRAM.

Parameters:
STARVE_LIMIT, 16, number of consecutive blocked cycles of a held host request before o_host_starved asserts (1..31)
WAIT_W, 5, width of the saturating host wait counter

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, synchronous, active-low
i_core_req_addr  input  8  core data request address
i_core_req_data  input  8  core write data
i_core_req_write  input  1  core write flag
i_core_req_valid  input  1  core request valid (no ready; always accepted)
o_core_rsp_data  output  8  read data to core, 1 cycle after request
i_host_req_addr  input  8  host request address
i_host_req_data  input  8  host write data
i_host_req_write  input  1  host write flag
i_host_req_valid  input  1  host request valid
o_host_req_ready  output  1  host request accepted when valid && ready
o_host_rsp_valid  output  1  host response/ack, 1 cycle after host issue
o_host_rsp_data  output  8  host read data (0 when rsp_valid low)
o_mem_req_addr  output  8  SRAM address
o_mem_req_data  output  8  SRAM write data
o_mem_req_write  output  1  SRAM write enable
o_mem_req_valid  output  1  SRAM access enable
i_mem_rsp_data  input  8  SRAM read data (1-cycle latency)
o_host_starved  output  1  held host request blocked >= STARVE_LIMIT cycles

Behaviour:
- Reset (synchronous, i_rst_n low at posedge): hold_valid_q=0, host_pend_q=0, wait_q=0.
- Output state while i_rst_n is low:
  - o_host_req_ready is forced 0 combinationally.
  - o_host_rsp_valid=0, o_host_starved=0.
- Reset mid-operation discards any held or in-flight host request; no response is produced for it.
- Host accept:
  - o_host_req_ready = i_rst_n && !hold_valid_q.
  - ready has no combinational dependency on i_host_req_valid or core inputs.
  - On valid && ready, capture addr/data/write and set hold_valid_q.
- Arbitration (combinational, per cycle):
  - If i_core_req_valid: memory port is driven from the core fields, valid=1.
  - Else if hold_valid_q: memory port is driven from the held fields, valid=1. This is a host issue; hold_valid_q clears at the next edge.
  - Else: valid=0, write=0, addr=0, data=0.
- Host throughput:
  - At most one host request per 2 cycles.
  - Ready re-asserts the cycle after issue; the holding register cannot be refilled in its issue cycle.
- Responses:
  - o_core_rsp_data = i_mem_rsp_data, unconditionally; the core qualifies it with its own pending flags.
  - host_pend_q <= host issue. o_host_rsp_valid = host_pend_q, for both reads and writes (writes act as an ack).
  - o_host_rsp_data = host_pend_q ? i_mem_rsp_data : 0.
- Wait counter:
  - wait_q increments, saturating at 2^WAIT_W-1, each cycle hold_valid_q && i_core_req_valid.
  - Clears on host issue.
  - o_host_starved = hold_valid_q && (wait_q >= STARVE_LIMIT). Status only; never preempts the core.
- Simultaneous events:
  - Core and held host request in the same cycle: core wins; host waits, wait_q+1.
  - Host accept in the same cycle as an unrelated host response: allowed.
- Write-then-read ordering: data written by the core is visible to a host read issued in any later cycle, and the converse also holds; the SRAM is write-first by construction.
- Address/data are 8-bit; there is no wrap logic, and the address 0xFF is legal.

Decomposition:
- h8_mem_pkg holds:
  - localparams H8_ADDR_W=8, H8_DATA_W=8.
  - A packed request encoding {write, addr, data} (17 bits) shared by the core, host and memory sides.
- Sub-module h8_req_hold: the one-entry holding register with valid/ready accept, clear-on-issue, and the saturating wait counter plus starved compare. The top level does only the mux and response tagging.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 2 cycles -> ready=0, rsp_valid=0, mem_valid=0. Release -> ready=1 the next cycle.
- Host write then read, core idle:
  - Write 0x5A to 0x10 -> mem_valid/write at 0x10 the cycle after accept, then rsp_valid=1 one cycle later.
  - Read 0x10 -> rsp_valid=1 with rsp_data=0x5A.
- Core priority: core reads 0x20 for 20 consecutive cycles while the host holds a read of 0x30:
  - Memory addr stays 0x20 throughout.
  - o_host_starved rises after 16 blocked cycles.
  - When core valid drops, the host issues at 0x30, starved falls, and rsp_valid follows one cycle later.
- Core store 0xA5 to 0x40 with a host read of 0x40 accepted in the same cycle -> the core write goes first, the host issues next cycle and returns 0xA5.
- Back-to-back host valid held high with 3 requests -> accepted on alternate cycles (ready pattern 1,0,1,0,1), three rsp_valid pulses, none lost.
- Reset asserted the cycle after host accept of a read of 0x50 -> no memory access to 0x50 and no rsp_valid after release.

Source files
------------

// File: rtl/h8_mem_pkg.sv
// Shared widths and request encoding for the h8 data-memory path.
// The same packed {write, addr, data} record is used on the core side,
// the host side and the SRAM side, so the arbiter is a plain mux.
package h8_mem_pkg;

    localparam int H8_ADDR_W = 8;
    localparam int H8_DATA_W = 8;
    localparam int H8_REQ_W  = 1 + H8_ADDR_W + H8_DATA_W;

    typedef struct packed {
        logic                 write;
        logic [H8_ADDR_W-1:0] addr;
        logic [H8_DATA_W-1:0] data;
    } h8_req_t;

    // Request presented to the SRAM on cycles with no access.
    function automatic h8_req_t h8_req_idle();
        return '0;
    endfunction

endpackage

// File: rtl/h8_req_hold.sv
// One-entry holding register for host requests.
// Accepts on valid && ready, releases on issue, and tracks how many cycles
// a held request has been blocked by the core (saturating) for status.
module h8_req_hold
    import h8_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int WAIT_W       = 5
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  h8_req_t i_req,
    input  logic    i_valid,
    output logic    o_ready,
    input  logic    i_issue,
    input  logic    i_blocked,
    output logic    o_hold_valid,
    output h8_req_t o_hold_req,
    output logic    o_starved
);

    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
    localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIMIT);

    logic              r_hold_valid;
    h8_req_t           r_hold_req;
    logic [WAIT_W-1:0] r_wait;
    logic              w_accept;

    // Ready depends only on reset and occupancy, never on the requesters,
    // so the entry cannot be refilled in the cycle it issues.
    assign o_ready  = i_rst_n && !r_hold_valid;
    assign w_accept = i_valid && o_ready;

    // Occupancy flag: set on accept, cleared when the entry issues.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
        end else if (i_issue) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Request payload is only meaningful while the entry is occupied.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_hold_req <= i_req;
        end
    end

    // Blocked-cycle counter: counts core-won cycles, restarts on issue.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wait <= '0;
        end else if (i_issue) begin
            r_wait <= '0;
        end else if (r_hold_valid && i_blocked && (r_wait != WAIT_MAX)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign o_hold_valid = r_hold_valid;
    assign o_hold_req   = r_hold_req;
    assign o_starved    = i_rst_n && r_hold_valid && (r_wait >= STARVE_THR);

endmodule

// File: rtl/h8_dmem_arbiter.sv
// Data-memory port arbiter between the h8 core and a host requester.
// The core cannot stall and always wins; the held host request uses
// cycles where the core is idle. SRAM read latency is one cycle.
module h8_dmem_arbiter
    import h8_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int WAIT_W       = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [H8_ADDR_W-1:0] i_core_req_addr,
    input  logic [H8_DATA_W-1:0] i_core_req_data,
    input  logic                 i_core_req_write,
    input  logic                 i_core_req_valid,
    output logic [H8_DATA_W-1:0] o_core_rsp_data,
    input  logic [H8_ADDR_W-1:0] i_host_req_addr,
    input  logic [H8_DATA_W-1:0] i_host_req_data,
    input  logic                 i_host_req_write,
    input  logic                 i_host_req_valid,
    output logic                 o_host_req_ready,
    output logic                 o_host_rsp_valid,
    output logic [H8_DATA_W-1:0] o_host_rsp_data,
    output logic [H8_ADDR_W-1:0] o_mem_req_addr,
    output logic [H8_DATA_W-1:0] o_mem_req_data,
    output logic                 o_mem_req_write,
    output logic                 o_mem_req_valid,
    input  logic [H8_DATA_W-1:0] i_mem_rsp_data,
    output logic                 o_host_starved
);

    h8_req_t w_core_req;
    h8_req_t w_host_req;
    h8_req_t w_hold_req;
    h8_req_t w_mem_req;
    logic    w_hold_valid;
    logic    w_host_issue;
    logic    w_mem_valid;
    logic    w_rsp_valid;
    logic    r_host_pend;

    assign w_core_req = {i_core_req_write, i_core_req_addr, i_core_req_data};
    assign w_host_req = {i_host_req_write, i_host_req_addr, i_host_req_data};

    h8_req_hold #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .WAIT_W       (WAIT_W)
    ) u_hold (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (w_host_req),
        .i_valid      (i_host_req_valid),
        .o_ready      (o_host_req_ready),
        .i_issue      (w_host_issue),
        .i_blocked    (i_core_req_valid),
        .o_hold_valid (w_hold_valid),
        .o_hold_req   (w_hold_req),
        .o_starved    (o_host_starved)
    );

    // A held request is never issued while reset is asserted, so a request
    // caught by reset produces neither an SRAM access nor a response.
    assign w_host_issue = i_rst_n && w_hold_valid && !i_core_req_valid;

    // Port mux: core first, then held host request, else a clean idle cycle.
    always_comb begin
        w_mem_req   = h8_req_idle();
        w_mem_valid = 1'b0;
        if (i_core_req_valid) begin
            w_mem_req   = w_core_req;
            w_mem_valid = 1'b1;
        end else if (w_host_issue) begin
            w_mem_req   = w_hold_req;
            w_mem_valid = 1'b1;
        end
    end

    assign o_mem_req_addr  = w_mem_req.addr;
    assign o_mem_req_data  = w_mem_req.data;
    assign o_mem_req_write = w_mem_req.write;
    assign o_mem_req_valid = w_mem_valid;

    // Tag the SRAM response cycle that belongs to a host issue.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_host_pend <= 1'b0;
        end else begin
            r_host_pend <= w_host_issue;
        end
    end

    // The core tracks its own outstanding reads, so it sees raw SRAM data.
    assign o_core_rsp_data  = i_mem_rsp_data;
    assign w_rsp_valid      = i_rst_n && r_host_pend;
    assign o_host_rsp_valid = w_rsp_valid;
    assign o_host_rsp_data  = w_rsp_valid ? i_mem_rsp_data : '0;

endmodule
